// File: rtl/cdb_broadcaster_pkg.sv
// Shared widths and the broadcast packet type used by the CDB and RS wakeup ports.
package cdb_broadcaster_pkg;

   localparam int unsigned ROB_TAG_LEN   = 6;
   localparam int unsigned XLEN          = 32;
   localparam int unsigned NUM_FU        = 4;
   localparam int unsigned FU_IDX_WIDTH  = 2;
   localparam int unsigned BUF_DEPTH     = 2;
   localparam int unsigned BUF_PTR_WIDTH = 1;

   typedef struct packed {
      logic                   valid;
      logic [ROB_TAG_LEN-1:0] tag;
      logic [XLEN-1:0]        value;
   } cdb_packet_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Per-FU result buffer: power-of-two depth, pointers wrap by truncation, flush empties it.
module cdb_result_fifo
   import cdb_broadcaster_pkg::*;
#(
   parameter int unsigned BufDepth    = 2,
   parameter int unsigned BufPtrWidth = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [ROB_TAG_LEN-1:0] push_tag_i,
   input  logic [XLEN-1:0]        push_value_i,
   input  logic                   pop_i,
   output logic [ROB_TAG_LEN-1:0] head_tag_o,
   output logic [XLEN-1:0]        head_value_o,
   output logic [BufPtrWidth:0]   count_o
);

   logic [ROB_TAG_LEN-1:0] tag_mem_q   [BufDepth];
   logic [XLEN-1:0]        value_mem_q [BufDepth];
   logic [BufPtrWidth-1:0] head_q, head_d;
   logic [BufPtrWidth-1:0] tail_q, tail_d;
   logic [BufPtrWidth:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_i) tail_d = tail_q + BufPtrWidth'(1);
      if (pop_i)  head_d = head_q + BufPtrWidth'(1);
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + (BufPtrWidth+1)'(1);
         2'b01:   count_d = count_q - (BufPtrWidth+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; count gates every read.
   always_ff @(posedge clk) begin
      if (push_i && !reset && !flush_i) begin
         tag_mem_q[tail_q]   <= push_tag_i;
         value_mem_q[tail_q] <= push_value_i;
      end
   end

   assign head_tag_o   = tag_mem_q[head_q];
   assign head_value_o = value_mem_q[head_q];
   assign count_o      = count_q;

endmodule

// File: rtl/cdb_broadcaster.sv
// Buffers FU results per unit and broadcasts one registered tag/value per cycle, round-robin.
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int unsigned NUM_FU        = cdb_broadcaster_pkg::NUM_FU,
   parameter int unsigned FU_IDX_WIDTH  = cdb_broadcaster_pkg::FU_IDX_WIDTH,
   parameter int unsigned BUF_DEPTH     = cdb_broadcaster_pkg::BUF_DEPTH,
   parameter int unsigned BUF_PTR_WIDTH = cdb_broadcaster_pkg::BUF_PTR_WIDTH
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                flush,
   input  logic [NUM_FU-1:0]                   fu_valid,
   input  logic [NUM_FU-1:0][ROB_TAG_LEN-1:0]  fu_tag,
   input  logic [NUM_FU-1:0][XLEN-1:0]         fu_value,
   output logic [NUM_FU-1:0]                   fu_ready,
   output logic                                cdb_valid,
   output logic [ROB_TAG_LEN-1:0]              cdb_tag,
   output logic [XLEN-1:0]                     cdb_value,
   output logic [FU_IDX_WIDTH-1:0]             cdb_fu_idx
);

   localparam logic [BUF_PTR_WIDTH:0] DepthCnt = (BUF_PTR_WIDTH+1)'(BUF_DEPTH);

   logic [BUF_PTR_WIDTH:0]   fifo_count [NUM_FU];
   logic [ROB_TAG_LEN-1:0]   head_tag   [NUM_FU];
   logic [XLEN-1:0]          head_value [NUM_FU];
   logic [NUM_FU-1:0]        fifo_pop;
   logic [NUM_FU-1:0]        fifo_push;

   logic                     grant_valid;
   logic [FU_IDX_WIDTH-1:0]  grant_idx;
   logic [FU_IDX_WIDTH-1:0]  cand;
   logic [FU_IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
   logic [FU_IDX_WIDTH-1:0]  fu_idx_q, fu_idx_d;
   cdb_packet_t              cdb_q, cdb_d;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      assign fu_ready[i]  = (fifo_count[i] != DepthCnt);
      assign fifo_push[i] = fu_valid[i] && fu_ready[i];
      assign fifo_pop[i]  = grant_valid && !flush && (grant_idx == FU_IDX_WIDTH'(i));

      cdb_result_fifo #(
         .BufDepth    (BUF_DEPTH),
         .BufPtrWidth (BUF_PTR_WIDTH)
      ) u_fifo (
         .clk          (clk),
         .reset        (reset),
         .flush_i      (flush),
         .push_i       (fifo_push[i]),
         .push_tag_i   (fu_tag[i]),
         .push_value_i (fu_value[i]),
         .pop_i        (fifo_pop[i]),
         .head_tag_o   (head_tag[i]),
         .head_value_o (head_value[i]),
         .count_o      (fifo_count[i])
      );
   end

   // First non-empty FIFO at or after rr_ptr, wrapping by index truncation.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         cand = rr_ptr_q + FU_IDX_WIDTH'(k);
         if (!grant_valid && (fifo_count[cand] != '0)) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      fu_idx_d    = fu_idx_q;
      cdb_d       = cdb_q;
      cdb_d.valid = 1'b0;
      if (flush) begin
         rr_ptr_d = '0;
      end else if (grant_valid) begin
         rr_ptr_d    = grant_idx + FU_IDX_WIDTH'(1);
         fu_idx_d    = grant_idx;
         cdb_d.valid = 1'b1;
         cdb_d.tag   = head_tag[grant_idx];
         cdb_d.value = head_value[grant_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_q <= '0;
         fu_idx_q <= '0;
         cdb_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         fu_idx_q <= fu_idx_d;
         cdb_q    <= cdb_d;
      end
   end

   assign cdb_valid  = cdb_q.valid;
   assign cdb_tag    = cdb_q.tag;
   assign cdb_value  = cdb_q.value;
   assign cdb_fu_idx = fu_idx_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench: per-FU queue model predicts each cycle's CDB output; a monitor compares.
module tb_cdb_broadcaster;
   import cdb_broadcaster_pkg::*;

   localparam int N = NUM_FU;

   logic                               clk = 1'b0;
   logic                               reset = 1'b1;
   logic                               flush = 1'b0;
   logic [N-1:0]                       fu_valid = '0;
   logic [N-1:0][ROB_TAG_LEN-1:0]      fu_tag = '0;
   logic [N-1:0][XLEN-1:0]             fu_value = '0;
   logic [N-1:0]                       fu_ready;
   logic                               cdb_valid;
   logic [ROB_TAG_LEN-1:0]             cdb_tag;
   logic [XLEN-1:0]                    cdb_value;
   logic [FU_IDX_WIDTH-1:0]            cdb_fu_idx;

   always #5 clk = ~clk;

   cdb_broadcaster dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .fu_valid   (fu_valid),
      .fu_tag     (fu_tag),
      .fu_value   (fu_value),
      .fu_ready   (fu_ready),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_value  (cdb_value),
      .cdb_fu_idx (cdb_fu_idx)
   );

   typedef struct packed {
      logic [ROB_TAG_LEN-1:0] tag;
      logic [XLEN-1:0]        value;
   } ent_t;

   typedef struct packed {
      logic                    v;
      logic [ROB_TAG_LEN-1:0]  tag;
      logic [XLEN-1:0]         value;
      logic [FU_IDX_WIDTH-1:0] idx;
      logic [N-1:0]            rdy;
   } exp_t;

   ent_t         mq [N][$];
   exp_t         exp_q [$];
   exp_t         last = '0;
   int           rr = 0;
   int           compared = 0;
   int           mismatched = 0;
   logic [N-1:0] pend = '0;
   ent_t         pe [N];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, want, $time);
      end
   endtask

   // Predicts the state right after the coming posedge from the inputs now being driven.
   task automatic model_step(output logic [N-1:0] acc);
      exp_t         e;
      ent_t         p;
      logic [N-1:0] rdy;
      int           g;
      acc = '0;
      e = last;
      e.v = 1'b0;
      for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < BUF_DEPTH);
      if (reset) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         rr = 0;
         e = '0;
      end else if (flush) begin
         for (int i = 0; i < N; i++) mq[i].delete();
         rr = 0;
      end else begin
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && mq[(rr + k) % N].size() > 0) g = (rr + k) % N;
         if (g >= 0) begin
            p = mq[g].pop_front();
            e.v = 1'b1;
            e.tag = p.tag;
            e.value = p.value;
            e.idx = FU_IDX_WIDTH'(g);
            rr = (g + 1) % N;
         end
         for (int i = 0; i < N; i++)
            if (fu_valid[i] && rdy[i]) begin
               mq[i].push_back('{fu_tag[i], fu_value[i]});
               acc[i] = 1'b1;
            end
      end
      for (int i = 0; i < N; i++) e.rdy[i] = (mq[i].size() < BUF_DEPTH);
      last = e;
      exp_q.push_back(e);
   endtask

   task automatic present(input int i, input int tag, input logic [XLEN-1:0] value);
      pend[i] = 1'b1;
      pe[i] = '{ROB_TAG_LEN'(tag), value};
   endtask

   // FUs hold a pending result and retry until accepted; squashed on flush/reset.
   task automatic cycle(input logic rst, input logic fl);
      logic [N-1:0] acc;
      @(negedge clk);
      reset = rst;
      flush = fl;
      fu_valid = pend;
      for (int i = 0; i < N; i++) begin
         fu_tag[i] = pe[i].tag;
         fu_value[i] = pe[i].value;
      end
      model_step(acc);
      pend = pend & ~acc;
      if (rst || fl) pend = '0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cdb_valid", 64'(cdb_valid), 64'(e.v));
            check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
            check("cdb_value", 64'(cdb_value), 64'(e.value));
            check("cdb_fu_idx", 64'(cdb_fu_idx), 64'(e.idx));
            check("fu_ready", 64'(fu_ready), 64'(e.rdy));
         end
      end
   end

   initial begin : stim
      for (int i = 0; i < N; i++) pe[i] = '0;
      repeat (2) cycle(1'b1, 1'b0);
      repeat (5) cycle(1'b0, 1'b0);

      present(1, 5, 32'hDEAD);
      cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b0);

      cycle(1'b0, 1'b1);
      for (int i = 0; i < N; i++) present(i, 10 + i, $urandom);
      cycle(1'b0, 1'b0);
      repeat (6) cycle(1'b0, 1'b0);

      for (int t = 0; t < 3; t++) begin
         present(2, 20 + t, $urandom);
         cycle(1'b0, 1'b0);
      end
      repeat (4) cycle(1'b0, 1'b0);

      for (int t = 0; t < 16; t++) begin
         if (!pend[0]) present(0, 30 + t, $urandom);
         if (!pend[3]) present(3, 50 + t, $urandom);
         cycle(1'b0, 1'b0);
      end
      repeat (4) cycle(1'b0, 1'b0);

      present(0, 40, 32'h4040);
      present(1, 41, 32'h4141);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      repeat (3) cycle(1'b0, 1'b0);

      for (int t = 0; t < 3000; t++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 99) < 60)
               present(i, int'($urandom_range(0, 63)), $urandom);
         cycle($urandom_range(0, 499) == 0, $urandom_range(0, 59) == 0);
      end

      pend = '0;
      repeat (8) cycle(1'b0, 1'b0);
      @(posedge clk);
      #2;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
